gpu_tile_mem_responder: RTL and testbench

Memory-side responder for the pixel cache's tile-fill read interface. It accepts burst read requests (`mem_req`/`mem_addr`/`mem_burst_len`) and queues them in order. Each burst is returned as a stream of `mem_rvalid`/`mem_rdata`/`mem_rlast` beats, honouring `mem_rready` backpressure. Data comes from an internal word-addressed backing store with a fixed, parameterised access latency; a preload write port fills that store. It stands in for the DRAM/fabric at the far end of the cache's fill path, in simulation and in FPGA bring-up.

---
 rtl/gpu_tile_mem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_gpu_tile_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_tile_mem_responder.sv
// Memory-side responder for the pixel cache tile-fill path.
// Queues burst read requests in order and streams each burst out of a
// word-addressed backing store with a fixed access latency and
// valid/ready backpressure. A preload port fills the store at any time.
module gpu_tile_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 32,
  parameter int MEM_DEPTH   = 4096,
  parameter int LATENCY     = 2,
  parameter int REQ_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_req,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [15:0]                  mem_burst_len,
  input  logic                         mem_rready,
  output logic                         mem_rvalid,
  output logic [PIXEL_WIDTH-1:0]       mem_rdata,
  output logic                         mem_rlast,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  input  logic [PIXEL_WIDTH-1:0]       wr_data,
  output logic                         busy,
  output logic                         req_overflow
);

  localparam int BYTE_SH = $clog2(PIXEL_WIDTH / 8);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int PTR_W   = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int QCNT_W  = $clog2(REQ_DEPTH + 1);
  localparam int CNT_W   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  // ---------------------------------------------------------------------
  // Request queue: {word index, burst length}
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  q_idx_mem [REQ_DEPTH];
  logic [15:0]       q_len_mem [REQ_DEPTH];
  logic [PTR_W-1:0]  q_wr_ptr_reg, q_rd_ptr_reg;
  logic [QCNT_W-1:0] q_count_reg, q_count_next;
  logic              q_full, q_empty, q_push, q_pop;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  head_idx;
  logic [15:0]       head_len;

  // Engine state
  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  addr_reg, addr_next;
  logic [15:0]       len_reg, len_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rvalid_reg, rvalid_next;
  logic              rlast_reg, rlast_next;
  logic              busy_reg, busy_next;
  logic              overflow_reg;

  // Backing store read port
  logic [PIXEL_WIDTH-1:0] store_mem [MEM_DEPTH];
  logic [PIXEL_WIDTH-1:0] rdata_reg;
  logic                   rd_en;
  logic [IDX_W-1:0]       rd_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(REQ_DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  // Byte address to word index; the truncation gives the modulo wrap.
  assign req_idx  = IDX_W'(mem_addr >> BYTE_SH);
  // Fullness is judged on the registered count, before any same-cycle pop.
  assign q_full   = (q_count_reg == QCNT_W'(REQ_DEPTH));
  assign q_empty  = (q_count_reg == '0);
  assign q_push   = mem_req && !q_full;
  assign q_pop    = (state_reg == IDLE) && !q_empty;
  assign head_idx = q_idx_mem[q_rd_ptr_reg];
  assign head_len = q_len_mem[q_rd_ptr_reg];

  // Queue storage writes (no reset needed; occupancy is tracked by count)
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_idx_mem[q_wr_ptr_reg] <= req_idx;
      q_len_mem[q_wr_ptr_reg] <= mem_burst_len;
    end
  end

  // Queue occupancy after this cycle's push/pop
  always_comb begin
    q_count_next = q_count_reg;
    case ({q_push, q_pop})
      2'b10:   q_count_next = q_count_reg + QCNT_W'(1);
      2'b01:   q_count_next = q_count_reg - QCNT_W'(1);
      default: q_count_next = q_count_reg;
    endcase
  end

  // Queue pointers, count and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr_ptr_reg <= '0;
      q_rd_ptr_reg <= '0;
      q_count_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (q_push) q_wr_ptr_reg <= ptr_inc(q_wr_ptr_reg);
      if (q_pop)  q_rd_ptr_reg <= ptr_inc(q_rd_ptr_reg);
      q_count_reg <= q_count_next;
      if (mem_req && q_full) overflow_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Burst engine: next-state, datapath updates and store read requests
  // ---------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    rvalid_next = rvalid_reg;
    rlast_next  = rlast_reg;
    rd_en       = 1'b0;
    rd_idx      = addr_reg;
    case (state_reg)
      IDLE: begin
        // Zero-length heads are popped and discarded without leaving IDLE.
        if (!q_empty && head_len != 16'd0) begin
          addr_next  = head_idx;
          len_next   = head_len;
          cnt_next   = CNT_W'(LATENCY);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          rd_en       = 1'b1;
          rd_idx      = addr_reg;
          rvalid_next = 1'b1;
          rlast_next  = (len_reg == 16'd1);
          state_next  = STREAM;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      STREAM: begin
        if (rvalid_reg && mem_rready) begin
          if (len_reg == 16'd1) begin
            rvalid_next = 1'b0;
            rlast_next  = 1'b0;
            state_next  = IDLE;
          end else begin
            // Index arithmetic wraps at the top of the store.
            addr_next  = addr_reg + IDX_W'(1);
            rd_en      = 1'b1;
            rd_idx     = addr_reg + IDX_W'(1);
            len_next   = len_reg - 16'd1;
            rlast_next = (len_reg == 16'd2);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (q_count_next != '0) || (state_next != IDLE);
  end

  // Engine state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      cnt_reg    <= cnt_next;
      rvalid_reg <= rvalid_next;
      rlast_reg  <= rlast_next;
      busy_reg   <= busy_next;
    end
  end

  // Backing store write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) store_mem[wr_addr] <= wr_data;
  end

  // Registered read into the beat register; a same-cycle write to the
  // same word is not visible here, so the beat carries the old data.
  always_ff @(posedge clk) begin
    if (rst)        rdata_reg <= '0;
    else if (rd_en) rdata_reg <= store_mem[rd_idx];
  end

  assign mem_rvalid   = rvalid_reg;
  assign mem_rdata    = rdata_reg;
  assign mem_rlast    = rlast_reg;
  assign busy         = busy_reg;
  assign req_overflow = overflow_reg;

endmodule

// File: tb/tb_gpu_tile_mem_responder.sv
// Self-checking bench for gpu_tile_mem_responder: stimulus pushes expected
// beats into a scoreboard queue, a negedge monitor pops and compares them.
module tb_gpu_tile_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [15:0] mem_burst_len = '0;
  logic        mem_rready = 1'b1;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy;
  logic        req_overflow;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit toggle_mode = 1'b0;

  // Scoreboard entries: {last, data}
  logic [32:0] sb[$];

  // Monitor state for stall stability
  bit          stall_pending = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always #5 clk = ~clk;

  gpu_tile_mem_responder #(
    .ADDR_WIDTH(32), .PIXEL_WIDTH(32), .MEM_DEPTH(4096),
    .LATENCY(2), .REQ_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_burst_len(mem_burst_len),
    .mem_rready(mem_rready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .req_overflow(req_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected beats for a burst against the A000_0000+i preload pattern
  task automatic push_burst(input logic [31:0] addr, input int len);
    int idx;
    idx = (addr >> 2) & 4095;
    for (int k = 0; k < len; k++)
      sb.push_back({(k == len - 1) ? 1'b1 : 1'b0, 32'hA000_0000 + 32'((idx + k) & 4095)});
  endtask

  // One-cycle request pulse; returns 1ns after the sampling edge
  task automatic issue(input logic [31:0] addr, input logic [15:0] len);
    mem_req = 1'b1;
    mem_addr = addr;
    mem_burst_len = len;
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, (n < 3000) ? 64'd1 : 64'd0, 64'd1);
    check({name, "_busy_idle"}, 64'(busy), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Ready driver: held high, or toggled every cycle during backpressure
  always @(posedge clk) begin
    #1;
    if (toggle_mode) mem_rready = ~mem_rready;
    else mem_rready = 1'b1;
  end

  // Monitor: compares each handshaked beat against the scoreboard head
  always @(negedge clk) begin
    logic [32:0] exp;
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (mem_rlast) check("rlast_with_rvalid", 64'(mem_rvalid), 64'd1);
      if (stall_pending) begin
        check("stall_hold_valid", 64'(mem_rvalid), 64'd1);
        check("stall_hold_data", 64'(mem_rdata), 64'(prev_data));
        check("stall_hold_last", 64'(mem_rlast), 64'(prev_last));
      end
      if (mem_rvalid && mem_rready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", mem_rdata);
        end else begin
          exp = sb.pop_front();
          $display("beat %0d data=%h last=%b expected data=%h last=%b",
                   hs_cnt, mem_rdata, mem_rlast, exp[31:0], exp[32]);
          check("beat_data", 64'(mem_rdata), 64'(exp[31:0]));
          check("beat_last", 64'(mem_rlast), 64'(exp[32]));
        end
        hs_cnt++;
      end
      stall_pending = mem_rvalid && !mem_rready;
      prev_data = mem_rdata;
      prev_last = mem_rlast;
    end
  end

  initial begin
    int n;
    int start;
    int mark;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rvalid", 64'(mem_rvalid), 64'd0);
    check("reset_rdata", 64'(mem_rdata), 64'd0);
    check("reset_rlast", 64'(mem_rlast), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(req_overflow), 64'd0);

    // Preload store[i] = A000_0000 + i
    for (int i = 0; i < 4096; i++) begin
      wr_en = 1'b1;
      wr_addr = 12'(i);
      wr_data = 32'hA000_0000 + 32'(i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    $display("preload done");

    // 1: single burst, latency and throughput
    push_burst(32'h40, 64);
    issue(32'h40, 16'd64);
    $display("req addr=40 len=64");
    check("t1_busy_after_push", 64'(busy), 64'd1);
    n = 0;
    while (!mem_rvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_first_beat_latency", 64'(n), 64'd4);
    mark = hs_cnt;
    repeat (64) begin
      @(posedge clk); #1;
    end
    check("t1_back_to_back_beats", 64'(hs_cnt - mark), 64'd64);
    wait_drain("t1");

    // 2: backpressure with ready toggling
    toggle_mode = 1'b1;
    push_burst(32'h40, 64);
    issue(32'h40, 16'd64);
    $display("req addr=40 len=64 backpressure");
    wait_drain("t2");
    toggle_mode = 1'b0;
    @(posedge clk); #1;

    // 3: six back-to-back requests, depth-4 queue, sixth dropped
    for (int i = 0; i < 6; i++) begin
      mem_req = 1'b1;
      mem_addr = 32'(i * 32'h100);
      mem_burst_len = 16'd4;
      if (i < 5) push_burst(32'(i * 32'h100), 4);
      $display("req addr=%0h len=4", i * 32'h100);
      @(posedge clk); #1;
    end
    mem_req = 1'b0;
    wait_drain("t3");
    check("t3_overflow_sticky", 64'(req_overflow), 64'd1);

    // 4: zero-length then length 2
    issue(32'h80, 16'd0);
    $display("req addr=80 len=0");
    push_burst(32'h80, 2);
    issue(32'h80, 16'd2);
    $display("req addr=80 len=2");
    wait_drain("t4");

    // 5: wrap at the top of the store
    push_burst(32'h3FFC, 3);
    issue(32'h3FFC, 16'd3);
    $display("req addr=3ffc len=3");
    wait_drain("t5");

    // 6a: reset in the middle of a burst
    start = hs_cnt;
    push_burst(32'h40, 64);
    issue(32'h40, 16'd64);
    $display("req addr=40 len=64 reset mid-burst");
    n = 0;
    while (hs_cnt < start + 10 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reached_beat10", (hs_cnt >= start + 10) ? 64'd1 : 64'd0, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_rvalid", 64'(mem_rvalid), 64'd0);
    check("t6_rst_rdata", 64'(mem_rdata), 64'd0);
    check("t6_rst_rlast", 64'(mem_rlast), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_overflow", 64'(req_overflow), 64'd0);
    rst = 1'b0;
    sb.delete();
    mark = hs_cnt;
    repeat (30) begin
      @(posedge clk); #1;
    end
    check("t6_no_beats_after_reset", 64'(hs_cnt), 64'(mark));
    check("t6_idle_after_reset", 64'(busy), 64'd0);
    push_burst(32'h40, 4);
    issue(32'h40, 16'd4);
    $display("req addr=40 len=4 after reset");
    wait_drain("t6_post_reset");

    // 6b: write to the word being loaded in the same cycle
    sb.push_back({1'b1, 32'hA000_0100});
    issue(32'h400, 16'd1);
    $display("req addr=400 len=1 with colliding write");
    repeat (3) begin
      @(posedge clk); #1;
    end
    wr_en = 1'b1;
    wr_addr = 12'h100;
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_drain("t6_collision_old");
    sb.push_back({1'b1, 32'hDEAD_BEEF});
    issue(32'h400, 16'd1);
    $display("req addr=400 len=1 reread");
    wait_drain("t6_collision_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
